// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit and the control unit that drives it.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Start/busy/done request bus between the control unit (master) and the muldiv engine (slave).
interface muldiv_seq_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             dzero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, dzero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, dzero, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide engine producing HI/LO; one iteration per cycle,
// operands reduced to magnitudes up front and the result sign restored in FIX.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_seq_if.slave   bus
);
  import muldiv_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_dzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_isdiv;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fix;

  assign w_isdiv  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_sa     = w_signed & bus.a_in[WIDTH-1];
  assign w_sb     = w_signed & bus.b_in[WIDTH-1];

  // |MIN| comes out as 2^(WIDTH-1), which is exact when read as unsigned
  muldiv_negate #(.WIDTH(WIDTH)) u_mag_a (.in(bus.a_in), .neg(w_sa), .out(w_ma));
  muldiv_negate #(.WIDTH(WIDTH)) u_mag_b (.in(bus.b_in), .neg(w_sb), .out(w_mb));

  // Multiply: r_acc = {partial hi, remaining multiplier bits}; r_opnd = multiplicand
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend/quotient bits}; r_opnd = divisor
  assign w_rsh      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rsh - {1'b0, r_opnd};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_p (.in(r_acc), .neg(r_neg_q), .out(w_prod));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_q (.in(r_acc[WIDTH-1:0]), .neg(r_neg_q), .out(w_quo));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_r (.in(r_acc[2*WIDTH-1:WIDTH]), .neg(r_neg_r), .out(w_rem));

  assign w_fix = r_div ? {w_rem, w_quo} : w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dzero <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div   <= w_isdiv;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_opnd  <= w_isdiv ? w_mb : w_ma;
            r_acc   <= {{WIDTH{1'b0}}, (w_isdiv ? w_ma : w_mb)};
            r_cnt   <= '0;
            if (w_isdiv && (bus.b_in == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_dzero <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_fix;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dzero <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.dzero  = r_dzero;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=32 and WIDTH=8 with hand-computed HI/LO values.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   dcount;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) b32 ();
  muldiv_seq_if #(.WIDTH(8))  b8 ();

  muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge with the engine in IDLE.
  task automatic op32(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int exp_edges, input logic exp_dz,
                      input logic [63:0] exp_res);
    int edges;
    bit busy_ok;
    b32.op = op; b32.a_in = a; b32.b_in = b; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    edges = 1; busy_ok = 1'b1;
    while (b32.done !== 1'b1 && edges < 200) begin
      if (b32.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " dzero"}, 64'(b32.dzero), 64'(exp_dz));
    check({tag, " hilo"}, {b32.hi_out, b32.lo_out}, exp_res);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(b32.done), 64'd0);
  endtask

  task automatic op8(input string tag, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, input int exp_edges, input logic [15:0] exp_res);
    int edges;
    b8.op = op; b8.a_in = a; b8.b_in = b; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    edges = 1;
    while (b8.done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " hilo"}, 64'({b8.hi_out, b8.lo_out}), 64'(exp_res));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(b8.done), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    b32.start = 1'b0; b32.op = OP_MULT; b32.a_in = '0; b32.b_in = '0;
    b8.start  = 1'b0; b8.op  = OP_MULT; b8.a_in  = '0; b8.b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs32", {59'd0, b32.busy, b32.done, b32.dzero, 2'b00}, 64'd0);
    check("reset hilo32", {b32.hi_out, b32.lo_out}, 64'd0);
    check("reset outs8", {48'd0, b8.hi_out, b8.lo_out} | {61'd0, b8.busy, b8.done, b8.dzero}, 64'd0);
    reset = 1'b0;

    op32("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 34, 1'b0, 64'hFFFFFFFF_FFFFFFEB);
    op32("multu max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0, 64'hFFFFFFFE_00000001);
    op32("mult -1*-1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0, 64'h00000000_00000001);
    op32("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
    op32("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 1'b0, 64'h00000000_80000000);
    op32("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 1'b0, 64'h00000001_FFFFFFFD);
    op32("divu 7/2", OP_DIVU, 32'd7, 32'd2, 34, 1'b0, 64'h00000001_00000003);
    op32("div 5/0", OP_DIV, 32'd5, 32'd0, 1, 1'b1, 64'h00000001_00000003);

    // A second start arriving mid-run must be dropped, not queued.
    b32.op = OP_MULTU; b32.a_in = 32'd3; b32.b_in = 32'd5; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    b32.op = OP_MULT; b32.a_in = 32'd7; b32.b_in = 32'd9; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b32.done === 1'b1) dcount++;
    end
    check("ignored start dones", 64'(dcount), 64'd1);
    check("ignored start hilo", {b32.hi_out, b32.lo_out}, 64'd15);

    b32.op = OP_MULTU; b32.a_in = 32'h1234; b32.b_in = 32'h10; b32.start = 1'b1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(b32.busy), 64'd0);
    check("abort done", 64'(b32.done), 64'd0);
    check("abort hilo", {b32.hi_out, b32.lo_out}, 64'd0);
    reset = 1'b0;
    op32("divu 100/7", OP_DIVU, 32'd100, 32'd7, 34, 1'b0, 64'h00000002_0000000E);

    op8("w8 mult 80*80", OP_MULT, 8'h80, 8'h80, 10, 16'h4000);
    op8("w8 div 80/ff", OP_DIV, 8'h80, 8'hFF, 10, 16'h0080);
    op8("w8 multu ff*ff", OP_MULTU, 8'hFF, 8'hFF, 10, 16'hFE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
